// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: commands, ALU opcodes, FSM states.
// Optional subtraction support is controlled by ALU_SEQ_SUB_EN in alu_sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_ADC = 2'd1,
      CMD_MOV = 2'd2,
      CMD_SUB = 2'd3
   } cmd_e;

   localparam logic [3:0] ALUOP_ADC  = 4'd0;
   localparam logic [3:0] ALUOP_ADD  = 4'd1;
   localparam logic [3:0] ALUOP_PASS = 4'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_EXE  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   // ADD ignores the incoming carry only on its least significant byte.
   function automatic logic [3:0] alu_op_for(input cmd_e c, input logic first);
      case (c)
         CMD_ADD:          return first ? ALUOP_ADD : ALUOP_ADC;
         CMD_ADC, CMD_SUB: return ALUOP_ADC;
         default:          return ALUOP_PASS;
      endcase
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences byte-wise ADD/ADC/MOV (and SUB when ALU_SEQ_SUB_EN is defined) over little-endian
// RAM operands through an external combinational 8-bit ALU, keeping carry/zero flags.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int AW   = 8,
   parameter int LENW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      cmd,
   input  logic [LENW-1:0] len,
   input  logic [AW-1:0]   base_a,
   input  logic [AW-1:0]   base_b,
   input  logic [AW-1:0]   base_d,
   output logic            busy,
   output logic            done,
   output logic            carry_flag,
   output logic            zero_flag,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [7:0]      mem_wdata,
   input  logic [7:0]      mem_rdata,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic            alu_carry,
   output logic [3:0]      alu_op,
   input  logic [7:0]      alu_c,
   input  logic            alu_carry_out,
   input  logic            alu_zero
);

   state_e            r_state;
   cmd_e              r_cmd;
   logic [LENW-1:0]   r_len, r_idx;
   logic [AW-1:0]     r_base_a, r_base_b, r_base_d;
   logic              r_chain, r_zacc, r_res_carry;
   logic [7:0]        r_a, r_b;
   logic [3:0]        r_op;
   logic [AW-1:0]     r_mem_addr;
   logic              r_mem_we;
   logic [7:0]        r_mem_wdata;
   logic              r_busy, r_done, r_carry_flag, r_zero_flag;

   cmd_e              w_cmd_eff;
   logic              w_chain_init, w_movlike, w_chain_next, w_zacc_next, w_last;
   logic [LENW-1:0]   w_idx_next;
   logic [AW-1:0]     w_idx_ext;
   logic [7:0]        w_b_in;
   logic              w_unused;

`ifdef ALU_SEQ_SUB_EN
   assign w_cmd_eff = cmd_e'(cmd);
   assign w_b_in    = (r_cmd == CMD_SUB) ? ~mem_rdata : mem_rdata;
`else
   // Without subtraction support, SUB is folded into MOV at command latch time.
   assign w_cmd_eff = (cmd == CMD_SUB) ? CMD_MOV : cmd_e'(cmd);
   assign w_b_in    = mem_rdata;
`endif

   assign w_chain_init = (w_cmd_eff == CMD_ADC) ? r_carry_flag : (w_cmd_eff == CMD_SUB);
   assign w_movlike    = (r_cmd == CMD_MOV);
   assign w_chain_next = w_movlike ? r_chain : r_res_carry;
   assign w_zacc_next  = r_zacc & (r_mem_wdata == 8'h00);
   assign w_idx_next   = r_idx + LENW'(1);
   assign w_last       = (w_idx_next == r_len);
   assign w_idx_ext    = AW'(r_idx);
   assign w_unused     = alu_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cmd        <= CMD_ADD;
         r_len        <= '0;
         r_idx        <= '0;
         r_base_a     <= '0;
         r_base_b     <= '0;
         r_base_d     <= '0;
         r_chain      <= 1'b0;
         r_zacc       <= 1'b1;
         r_res_carry  <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= ALUOP_ADC;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_carry_flag <= 1'b0;
         r_zero_flag  <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            ST_IDLE: if (start) begin
               r_cmd    <= w_cmd_eff;
               r_len    <= len;
               r_base_a <= base_a;
               r_base_b <= base_b;
               r_base_d <= base_d;
               r_idx    <= '0;
               r_chain  <= w_chain_init;
               r_zacc   <= 1'b1;
               r_busy   <= 1'b1;
               if (len == '0) begin
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
                  r_zero_flag <= 1'b1;
               end else begin
                  r_state    <= ST_RDA;
                  r_mem_addr <= base_a;
               end
            end
            ST_RDA: begin
               r_state    <= ST_RDB;
               r_mem_addr <= r_base_b + w_idx_ext;
            end
            ST_RDB: begin
               r_a     <= mem_rdata;
               r_op    <= alu_op_for(r_cmd, r_idx == '0);
               r_state <= ST_EXE;
            end
            ST_EXE: begin
               r_b         <= w_b_in;
               r_mem_wdata <= alu_c;
               r_res_carry <= alu_carry_out;
               r_mem_addr  <= r_base_d + w_idx_ext;
               r_mem_we    <= 1'b1;
               r_state     <= ST_WR;
            end
            ST_WR: begin
               r_chain <= w_chain_next;
               r_zacc  <= w_zacc_next;
               r_idx   <= w_idx_next;
               if (w_last) begin
                  r_state      <= ST_DONE;
                  r_done       <= 1'b1;
                  r_carry_flag <= w_movlike ? 1'b0 : w_chain_next;
                  r_zero_flag  <= w_zacc_next;
               end else begin
                  r_state    <= ST_RDA;
                  r_mem_addr <= r_base_a + AW'(w_idx_next);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign carry_flag = r_carry_flag;
   assign zero_flag  = r_zero_flag;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;
   assign alu_a      = r_a;
   // B is fed straight from the RAM during EXE so the ALU result is ready at the end of EXE.
   assign alu_b      = (r_state == ST_EXE) ? w_b_in : r_b;
   assign alu_carry  = r_chain;
   assign alu_op     = r_op;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: bench-side RAM and ALU models, expected writes queued per command.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'd0;
   logic [3:0] len = 4'd0;
   logic [7:0] base_a = 8'd0, base_b = 8'd0, base_d = 8'd0;
   logic       busy, done, carry_flag, zero_flag;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [7:0] alu_a, alu_b, alu_c;
   logic       alu_carry, alu_carry_out, alu_zero;
   logic [3:0] alu_op;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t sb_q[$];

   logic [7:0] ram[256];
   logic [7:0] model_mem[256];
   bit         exp_cf = 1'b0;
   bit         exp_zf = 1'b0;

   always #5 clk = ~clk;

   alu_sequencer #(.AW(8), .LENW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .len(len),
      .base_a(base_a), .base_b(base_b), .base_d(base_d),
      .busy(busy), .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry), .alu_op(alu_op),
      .alu_c(alu_c), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
   );

   always @(posedge clk) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   always_comb begin
      logic [8:0] s;
      s = 9'd0;
      case (alu_op)
         4'd0:    s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
         4'd1:    s = {1'b0, alu_a} + {1'b0, alu_b};
         default: s = {1'b0, alu_a};
      endcase
      alu_c         = s[7:0];
      alu_carry_out = s[8];
      alu_zero      = (s[7:0] == 8'd0);
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (mem_we === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_value("unexpected_we", {24'd0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            check_value("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
            check_value("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
         end
      end
   end

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ram[a]       <= d;
      model_mem[a] = d;
   endtask

   // rst_at != 0 asserts reset during that cycle after the start edge.
   task automatic run_cmd(input logic [1:0] c, input logic [3:0] l, input logic [7:0] ba,
                          input logic [7:0] bb, input logic [7:0] bd,
                          input bit pulse_mid, input int rst_at);
      logic [7:0] a, b, r, aa, ab, ad;
      logic [8:0] s;
      bit ch, z, sub_en, is_sub, is_mov;
      int n;
`ifdef ALU_SEQ_SUB_EN
      sub_en = 1'b1;
`else
      sub_en = 1'b0;
`endif
      is_sub = (c == 2'd3) && sub_en;
      is_mov = (c == 2'd2) || ((c == 2'd3) && !sub_en);
      ch = (c == 2'd1) ? exp_cf : is_sub;
      z  = 1'b1;
      for (int j = 0; j < int'(l); j++) begin
         aa = ba + 8'(j);
         ab = bb + 8'(j);
         ad = bd + 8'(j);
         a = model_mem[aa];
         b = model_mem[ab];
         if (is_mov) begin
            r = a;
         end else begin
            s  = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {8'd0, ch};
            r  = s[7:0];
            ch = s[8];
         end
         z = z & (r == 8'd0);
         if (rst_at == 0 || (4 + 4 * j) < rst_at) begin
            sb_q.push_back('{ad, r});
            model_mem[ad] = r;
         end
      end
      if (rst_at != 0) begin
         exp_cf = 1'b0;
         exp_zf = 1'b0;
      end else if (l != 4'd0) begin
         exp_cf = is_mov ? 1'b0 : ch;
         exp_zf = z;
      end else begin
         exp_zf = 1'b1;
      end

      @(negedge clk);
      start = 1'b1; cmd = c; len = l; base_a = ba; base_b = bb; base_d = bd;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check_value("busy_first", {31'd0, busy}, 32'd1);
      while (n < 200) begin
         if (rst_at != 0 && n == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_value("rst_busy", {31'd0, busy}, 32'd0);
            check_value("rst_done", {31'd0, done}, 32'd0);
            check_value("rst_we", {31'd0, mem_we}, 32'd0);
            check_value("rst_cf", {31'd0, carry_flag}, 32'd0);
            check_value("rst_zf", {31'd0, zero_flag}, 32'd0);
            break;
         end
         if (done === 1'b1) break;
         if (pulse_mid && n == 3) begin
            start = 1'b1; base_d = 8'hE0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (rst_at != 0) begin
         repeat (12) @(negedge clk);
         check_value("rst_idle_busy", {31'd0, busy}, 32'd0);
      end else begin
         check_value("done_seen", {31'd0, done}, 32'd1);
         check_value("latency", n, 1 + 4 * int'(l));
         check_value("busy_in_done", {31'd0, busy}, 32'd1);
         check_value("carry_flag", {31'd0, carry_flag}, {31'd0, exp_cf});
         check_value("zero_flag", {31'd0, zero_flag}, {31'd0, exp_zf});
         @(negedge clk);
         check_value("done_pulse", {31'd0, done}, 32'd0);
         check_value("busy_after", {31'd0, busy}, 32'd0);
      end
      check_value("sb_empty", sb_q.size(), 32'd0);
      $display("txn cmd=%0d len=%0d a=%02h b=%02h d=%02h cycles=%0d cf=%0b zf=%0b",
               c, l, ba, bb, bd, n, carry_flag, zero_flag);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) poke(8'(i), 8'(i) ^ 8'h5A);
      repeat (3) @(negedge clk);
      check_value("reset_busy", {31'd0, busy}, 32'd0);
      check_value("reset_done", {31'd0, done}, 32'd0);
      check_value("reset_we", {31'd0, mem_we}, 32'd0);
      check_value("reset_addr", {24'd0, mem_addr}, 32'd0);
      check_value("reset_wdata", {24'd0, mem_wdata}, 32'd0);
      check_value("reset_cf", {31'd0, carry_flag}, 32'd0);
      check_value("reset_zf", {31'd0, zero_flag}, 32'd0);
      rst = 1'b0;

      // ADD 0x12FF + 0x0001, with a start pulse while busy
      poke(8'h00, 8'hFF); poke(8'h01, 8'h12);
      poke(8'h10, 8'h01); poke(8'h11, 8'h00);
      run_cmd(2'd0, 4'd2, 8'h00, 8'h10, 8'h20, 1'b1, 0);

      // ADD 0xFFFF + 0x0001 -> zero with carry
      poke(8'h40, 8'hFF); poke(8'h41, 8'hFF);
      poke(8'h48, 8'h01); poke(8'h49, 8'h00);
      run_cmd(2'd0, 4'd2, 8'h40, 8'h48, 8'h50, 1'b0, 0);

      // len=0 keeps carry, forces zero
      run_cmd(2'd1, 4'd0, 8'h40, 8'h48, 8'h50, 1'b0, 0);

      // ADC 0x00 + 0x00 + carry
      poke(8'h60, 8'h00); poke(8'h61, 8'h00);
      run_cmd(2'd1, 4'd1, 8'h60, 8'h61, 8'h62, 1'b0, 0);

      // MOV in place shifted by one, then a plain copy
      poke(8'h30, 8'hA1); poke(8'h31, 8'hB2); poke(8'h32, 8'hC3);
      run_cmd(2'd2, 4'd3, 8'h30, 8'h10, 8'h31, 1'b0, 0);
      poke(8'h70, 8'h11); poke(8'h71, 8'h22); poke(8'h72, 8'h33);
      run_cmd(2'd2, 4'd3, 8'h70, 8'h10, 8'h80, 1'b0, 0);

      // Address wrap on A
      poke(8'hFF, 8'h34); poke(8'h00, 8'h56);
      poke(8'h90, 8'h01); poke(8'h91, 8'h02);
      run_cmd(2'd0, 4'd2, 8'hFF, 8'h90, 8'hA0, 1'b0, 0);

      // SUB (or MOV when subtraction is not built in)
      poke(8'hB0, 8'h05); poke(8'hB1, 8'h07);
      run_cmd(2'd3, 4'd1, 8'hB0, 8'hB1, 8'hB2, 1'b0, 0);

      // Set both flags, then reset during EXE of byte 1
      run_cmd(2'd0, 4'd2, 8'h40, 8'h48, 8'h50, 1'b0, 0);
      poke(8'h40, 8'hFF); poke(8'h41, 8'hFF);
      run_cmd(2'd0, 4'd2, 8'h40, 8'h48, 8'hC0, 1'b0, 7);

      // Recovery after reset
      poke(8'hD0, 8'h10); poke(8'hD1, 8'h20);
      run_cmd(2'd1, 4'd1, 8'hD0, 8'hD1, 8'hD2, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Controller that drives the 8-bit ALU to execute multi-byte ADD/ADC/MOV operations on little-endian operands held in a byte-wide synchronous RAM. It sequences read A, read B, execute, write back per byte and chains carry between bytes. It keeps architectural carry/zero flags. It sits between the command source (CPU decode or host bridge), the RAM and the ALU.

Parameters:
AW, 8, RAM address width; all address arithmetic wraps modulo 2^AW
LENW, 4, width of byte-count field

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  command strobe, accepted only in IDLE
cmd  in  2  0=ADD, 1=ADC, 2=MOV (copy A), 3=SUB (optional, see below)
len  in  LENW  operand length in bytes
base_a  in  AW  address of A byte 0 (LSB)
base_b  in  AW  address of B byte 0
base_d  in  AW  destination address of byte 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
carry_flag  out  1  architectural carry
zero_flag  out  1  high when entire multi-byte result is 0
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid one cycle after address
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_carry  out  1  ALU carry in
alu_op  out  4  ALU opcode: 0=a+b+carry, 1=a+b, 2=pass A
alu_c  in  8  ALU result
alu_carry_out  in  1  ALU carry out
alu_zero  in  1  ALU zero (unused; zero accumulated internally)

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: state IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, carry_flag=0, zero_flag=0, byte index=0. Reset mid-operation aborts immediately; no further write occurs after the reset edge.
- FSM: IDLE -> RDA -> RDB -> EXE -> WR -> (RDA if bytes remain, else DONE) -> IDLE.
- IDLE: start=1 latches cmd/len/bases, index i=0, chain carry = (cmd==ADC ? carry_flag : 0), zero accumulator=1. A start while busy is ignored.
- RDA: mem_addr=base_a+i.
- RDB: latch mem_rdata as A byte; mem_addr=base_b+i.
- EXE: latch mem_rdata as B byte. ALU is combinational. Latch alu_c and alu_carry_out. Opcode is 1 for ADD at i=0, 0 otherwise for ADD/ADC, and 2 for MOV. alu_carry = chain carry. MOV leaves chain carry unchanged at 0.
- WR: mem_addr=base_d+i, mem_we=1, mem_wdata=latched result. Update chain carry and zero accumulator (&= result==0). Increment i.
- DONE: done=1 for exactly one cycle. carry_flag=chain carry (MOV: 0). zero_flag=accumulator.
- Timing: start accepted at edge k; done high during cycle k+1+4*len; busy high from k+1 through the DONE cycle inclusive.
- len=0: IDLE->DONE directly, no memory access, carry_flag unchanged, zero_flag=1.
- Address wrap: base+i rolls over modulo 2^AW.
- Overlapping destination and source: each byte is read before it is written, so byte-in-place operation (base_d==base_a) is correct.
- mem_we is high only in WR.
- Outside EXE, alu_a, alu_b and alu_op hold their last value; they are don't-care.

Optional Feature:
ALU_SEQ_SUB_EN
- Defined: cmd=3 computes A-B. alu_b=~B. ALU opcode 0 for all bytes. Initial chain carry=1. carry_flag=1 means no borrow.
- Undefined: cmd=3 behaves exactly as MOV.

Decomposition:
- Shared package alu_seq_pkg holds:
  - cmd encodings CMD_ADD/ADC/MOV/SUB
  - ALU opcode constants ALUOP_ADC=0, ALUOP_ADD=1, ALUOP_PASS=2
  - state encoding constants
- No sub-module: the ALU stays a sibling instance wired at the top level. The FSM plus address adder fits one module.

Test Plan:
- ADD, len=2, A=0x12FF @0x00, B=0x0001 @0x10, dst 0x20 -> RAM[0x20]=0x00, RAM[0x21]=0x13; carry_flag=0, zero_flag=0; done at cycle k+9.
- ADD, len=2, A=0xFFFF, B=0x0001 -> result 0x0000; carry_flag=1, zero_flag=1. Then ADC, len=1, A=0x00, B=0x00 -> result 0x01 (carry used), carry_flag=0.
- MOV, len=3, base_d=base_a+1 -> in-place shift yields RAM[a+1..a+3]=original A[0] repeated. Variant with base_d distinct -> exact copy; carry_flag=0.
- Wrap: base_a=0xFF, len=2 -> reads 0xFF then 0x00. len=0 -> done at k+1, no mem_we, zero_flag=1.
- Start pulsed during busy is ignored. Assert rst in the EXE of byte 1 -> next cycle busy=0, no further mem_we, flags=0.
- With ALU_SEQ_SUB_EN, SUB, len=1, A=0x05, B=0x07 -> 0xFE, carry_flag=0. Without it -> result 0x05 (MOV).
